// File: rtl/multibyte_add_seq_pkg.sv
// Shared constants and state encoding for the byte-serial add/sub sequencer.
// Imported by the sequencer top and its byte adder.
package multibyte_add_seq_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/multibyte_add_seq_adder_byte.sv
// Shared 8-bit adder with carry in/out.
// The sequencer feeds it one operand byte per clock.
module multibyte_add_seq_adder_byte
  import multibyte_add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              carry_in,
  output logic [BYTE_W-1:0] sum,
  output logic              carry_out
);

  assign {carry_out, sum} = {1'b0, a}
                          + {1'b0, b}
                          + {{BYTE_W{1'b0}}, carry_in};

endmodule

// File: rtl/multibyte_add_seq.sv
// NBYTES-wide add/subtract done LSB-first through one byte adder.
// start/ready/done handshake; result and flags are registered.
module multibyte_add_seq
  import multibyte_add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [8*NBYTES-1:0]    a,
  input  logic [8*NBYTES-1:0]    b,
  output logic                   ready,
  output logic                   done,
  output logic [8*NBYTES-1:0]    result,
  output logic                   carry_out,
  output logic                   overflow
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t              r_state;
  logic [W-1:0]        r_opa;
  logic [W-1:0]        r_opb;
  logic [W-1:0]        r_acc;
  logic                r_carry;
  logic [IDX_W-1:0]    r_idx;
  logic [W-1:0]        r_result;
  logic                r_cout;
  logic                r_ovf;
  logic                r_done;
  logic                r_ready;

  logic [BYTE_W-1:0]   w_sum;
  logic                w_cout;
  logic [W-1:0]        w_acc_nxt;
  logic                w_last;
  logic                w_ovf;

  multibyte_add_seq_adder_byte u_adder_byte (
    .a         (r_opa[BYTE_W-1:0]),
    .b         (r_opb[BYTE_W-1:0]),
    .carry_in  (r_carry),
    .sum       (w_sum),
    .carry_out (w_cout)
  );

  // New byte enters at the top; after NBYTES shifts the word is in place.
  assign w_acc_nxt = W'({w_sum, r_acc} >> BYTE_W);
  assign w_last    = (r_idx == IDX_W'(NBYTES - 1));

  // On the MSB byte, bit 7 of each operand is the sign bit.
  assign w_ovf = (r_opa[BYTE_W-1] == r_opb[BYTE_W-1])
              && (w_sum[BYTE_W-1] != r_opa[BYTE_W-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa   <= a;
            r_opb   <= op_sub ? ~b : b;
            r_carry <= op_sub;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_nxt;
          r_opa   <= r_opa >> BYTE_W;
          r_opb   <= r_opb >> BYTE_W;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_result <= w_acc_nxt;
            r_cout   <= w_cout;
            r_ovf    <= w_ovf;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed self-checking bench for multibyte_add_seq (NBYTES=4).
// Vector table plus hand sequences for busy, reset and back-to-back.
module tb_multibyte_add_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int done_cyc;

  multibyte_add_seq #(.NBYTES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        c;
    logic        v;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one operation and returns in the cycle where done is high.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic [31:0] er,
                        input logic ec, input logic ev,
                        input string nm, input bit poke);
    int n;
    logic [31:0] prev;
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " ready_idle"}, {31'd0, ready}, 32'd1);
    prev   = result;
    a      = ia;
    b      = ib;
    op_sub = isub;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    a      = ~ia;
    b      = ~ib;
    op_sub = ~isub;
    chk({nm, " ready_busy"}, {31'd0, ready}, 32'd0);
    n = 0;
    while (n < 20) begin
      if (poke && n == 1) begin
        a     = 32'h11111111;
        b     = 32'h11111111;
        start = 1'b1;
      end
      @(posedge clk); #1; n++;
      start = 1'b0;
      if (done) break;
      chk({nm, " result_hold"}, result, prev);
      chk({nm, " ready_run"}, {31'd0, ready}, 32'd0);
    end
    chk({nm, " latency"}, n, 4);
    chk({nm, " ready_done"}, {31'd0, ready}, 32'd0);
    chk({nm, " result"}, result, er);
    chk({nm, " carry"}, {31'd0, carry_out}, {31'd0, ec});
    chk({nm, " overflow"}, {31'd0, overflow}, {31'd0, ev});
    done_cyc = cyc;
  endtask

  vec_t vt[8];
  int   first_done;

  initial begin
    vt[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, "add_bytecarry"};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, "add_wrap"};
    vt[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, "add_sovf"};
    vt[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_borrow"};
    vt[4] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, "sub_noborrow"};
    vt[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "sub_sovf"};
    vt[6] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, "add_mixed"};
    vt[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, "add_negovf"};

    reset  = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst carry", {31'd0, carry_out}, 32'd0);
    chk("rst ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].sub, vt[i].res,
             vt[i].c, vt[i].v, vt[i].nm, 1'b0);
      @(posedge clk); #1;
      chk({vt[i].nm, " done_pulse"}, {31'd0, done}, 32'd0);
      chk({vt[i].nm, " ready_back"}, {31'd0, ready}, 32'd1);
    end

    // Busy: a start during RUN must be dropped.
    run_op(32'h00000010, 32'h00000020, 1'b0, 32'h00000030,
           1'b0, 1'b0, "busy", 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("busy no_extra_done", {31'd0, done}, 32'd0);
    end
    chk("busy result_kept", result, 32'h00000030);

    // Reset two cycles into a run.
    a      = 32'h0000FFFF;
    b      = 32'h00000001;
    op_sub = 1'b0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst ready", {31'd0, ready}, 32'd1);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst carry", {31'd0, carry_out}, 32'd0);
    chk("midrst ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("midrst no_done", {31'd0, done}, 32'd0);
    end
    run_op(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000,
           1'b0, 1'b0, "post_rst", 1'b0);

    // Back-to-back: second start in the first IDLE cycle.
    @(posedge clk); #1;
    run_op(32'h00000003, 32'h00000004, 1'b0, 32'h00000007,
           1'b0, 1'b0, "b2b_1", 1'b0);
    first_done = done_cyc;
    run_op(32'h00000100, 32'h00000001, 1'b1, 32'h000000FF,
           1'b1, 1'b0, "b2b_2", 1'b0);
    chk("b2b spacing", done_cyc - first_done, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
